// File: rtl/ifu_pkg.sv
// Types and helpers shared by the instruction-fetch cache and its refill responder.
// The line/word ratio fixes the beat count of every refill burst.
package ifu_pkg;

  localparam int unsigned IFU_LINE_WIDTH = 128;
  localparam int unsigned IFU_TAG_WIDTH  = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } t_refill_state;

  typedef logic [IFU_LINE_WIDTH-1:0] t_line;
  typedef logic [IFU_TAG_WIDTH-1:0]  t_tag;

  function automatic int unsigned beatsOf(input int unsigned lineWidth,
                                          input int unsigned wordWidth);
    return lineWidth / wordWidth;
  endfunction

endpackage

// File: rtl/ifu_refill_fifo.sv
// Small request FIFO for the refill responder (power-of-2 depth, flop storage).
// With IFU_REFILL_DEDUP_EN defined it also reports whether a tag matches any live entry.
module ifu_refill_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Rst,
  input  logic             pushIn,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             popIn,
  output logic [WIDTH-1:0] headOut,
  output logic             fullOut,
  output logic             emptyOut
`ifdef IFU_REFILL_DEDUP_EN
  ,
  input  logic [WIDTH-1:0] cmpTagIn,
  output logic             cmpHitOut
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W:0]   count;

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      // A push into a full FIFO only arrives together with a pop, so it reuses the head slot.
      if (pushIn) begin
        entries[wrPtr] <= dataIn;
        wrPtr          <= wrPtr + PTR_ONE;
      end
      if (popIn) rdPtr <= rdPtr + PTR_ONE;
      case ({pushIn, popIn})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  assign headOut  = entries[rdPtr];
  assign fullOut  = (count == CNT_FULL);
  assign emptyOut = (count == '0);

`ifdef IFU_REFILL_DEDUP_EN
  logic [DEPTH-1:0] hitVec;
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : gCmp
    logic [PTR_W-1:0] offset;
    // An entry is live when its distance from the read pointer is below the fill count.
    assign offset     = PTR_W'(gi) - rdPtr;
    assign hitVec[gi] = ({1'b0, offset} < count) && (entries[gi] == cmpTagIn);
  end
  assign cmpHitOut = |hitVec;
`endif

endmodule

// File: rtl/ifu_mem_refill.sv
// Refill responder: queues line requests, bursts each line out of word-wide imem, returns it as one pulse.
// IFU_REFILL_DEDUP_EN: drop requests whose tag is already queued or in flight.
module ifu_mem_refill
  import ifu_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 4,
  parameter int TAG_WIDTH    = 28,
  parameter int LINE_WIDTH   = 128,
  parameter int WORD_WIDTH   = 32,
  parameter int REQ_DEPTH    = 2
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [TAG_WIDTH-1:0]  mem_reqTagIn,
  input  logic                  mem_reqTagValidIn,
  output logic [TAG_WIDTH-1:0]  mem_rspTagOut,
  output logic [LINE_WIDTH-1:0] mem_rspInsLineOut,
  output logic                  mem_rspInsLineValidOut,
  output logic                  imem_rdEnOut,
  output logic [ADDR_WIDTH-1:0] imem_rdAddrOut,
  input  logic [WORD_WIDTH-1:0] imem_rdDataIn,
  output logic                  busyOut,
  output logic                  ovfStickyOut
);

  localparam int BEATS  = beatsOf(LINE_WIDTH, WORD_WIDTH);
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  t_refill_state          stateReg;
  logic [BEAT_W-1:0]      beatReg;
  logic [TAG_WIDTH-1:0]   tagReg;
  logic                   rdEnReg;
  logic                   rspValidReg;
  logic                   ovfReg;

  logic [TAG_WIDTH-1:0]   fifoHead;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic                   fifoPop;
  logic                   fifoPush;
  logic                   dupHit;
  logic                   reqLive;
  logic                   captureEn;
  logic [BEAT_W-1:0]      slotIdx;
  logic [OFFSET_WIDTH-1:0] lineOffset;

  assign fifoPop  = !fifoEmpty && ((stateReg == IDLE) || (stateReg == RESP));
  assign reqLive  = mem_reqTagValidIn && !dupHit;
  assign fifoPush = reqLive && (!fifoFull || fifoPop);

`ifdef IFU_REFILL_DEDUP_EN
  logic fifoHit;
  assign dupHit = mem_reqTagValidIn &&
                  (fifoHit || ((stateReg != IDLE) && (tagReg == mem_reqTagIn)));
`else
  assign dupHit = 1'b0;
`endif

  ifu_refill_fifo #(
    .WIDTH (TAG_WIDTH),
    .DEPTH (REQ_DEPTH)
  ) u_fifo (
    .Clock    (Clock),
    .Rst      (Rst),
    .pushIn   (fifoPush),
    .dataIn   (mem_reqTagIn),
    .popIn    (fifoPop),
    .headOut  (fifoHead),
    .fullOut  (fifoFull),
    .emptyOut (fifoEmpty)
`ifdef IFU_REFILL_DEDUP_EN
    ,
    .cmpTagIn (mem_reqTagIn),
    .cmpHitOut(fifoHit)
`endif
  );

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      stateReg    <= IDLE;
      beatReg     <= '0;
      tagReg      <= '0;
      rdEnReg     <= 1'b0;
      rspValidReg <= 1'b0;
      ovfReg      <= 1'b0;
    end else begin
      rspValidReg <= 1'b0;
      if (reqLive && fifoFull && !fifoPop) ovfReg <= 1'b1;
      unique case (stateReg)
        IDLE: begin
          if (!fifoEmpty) begin
            tagReg   <= fifoHead;
            beatReg  <= '0;
            rdEnReg  <= 1'b1;
            stateReg <= READ;
          end
        end
        READ: begin
          // Wraps back to 0 after the last beat, which WAIT relies on to address its capture slot.
          beatReg <= beatReg + BEAT_ONE;
          if (beatReg == LAST_BEAT) begin
            rdEnReg  <= 1'b0;
            stateReg <= WAIT;
          end
        end
        WAIT: begin
          rspValidReg <= 1'b1;
          stateReg    <= RESP;
        end
        RESP: begin
          if (!fifoEmpty) begin
            tagReg   <= fifoHead;
            beatReg  <= '0;
            rdEnReg  <= 1'b1;
            stateReg <= READ;
          end else begin
            stateReg <= IDLE;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  // Read data lags the address by one cycle, so it belongs to the previously issued beat.
  assign captureEn = ((stateReg == READ) && (beatReg != '0)) || (stateReg == WAIT);
  assign slotIdx   = beatReg - BEAT_ONE;

  genvar gi;
  for (gi = 0; gi < BEATS; gi++) begin : gLine
    logic [WORD_WIDTH-1:0] wordReg;
    always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
        wordReg <= '0;
      end else if (captureEn && (slotIdx == BEAT_W'(gi))) begin
        wordReg <= imem_rdDataIn;
      end
    end
    assign mem_rspInsLineOut[gi*WORD_WIDTH +: WORD_WIDTH] = wordReg;
  end

  assign lineOffset             = {beatReg, 2'b00};
  assign imem_rdAddrOut         = {tagReg, lineOffset};
  assign imem_rdEnOut           = rdEnReg;
  assign mem_rspTagOut          = tagReg;
  assign mem_rspInsLineValidOut = rspValidReg;
  assign busyOut                = (stateReg != IDLE) || !fifoEmpty;
  assign ovfStickyOut           = ovfReg;

endmodule

// File: tb/tb_ifu_mem_refill.sv
// Bench for ifu_mem_refill: transaction-level queue/server model checked every cycle,
// plus directed literal checks. Honours IFU_REFILL_DEDUP_EN like the design.
module tb_ifu_mem_refill;

  logic         Clock;
  logic         Rst;
  logic [27:0]  reqTag;
  logic         reqValid;
  logic [27:0]  mem_rspTagOut;
  logic [127:0] mem_rspInsLineOut;
  logic         mem_rspInsLineValidOut;
  logic         imem_rdEnOut;
  logic [31:0]  imem_rdAddrOut;
  logic [31:0]  imem_rdDataIn;
  logic         busyOut;
  logic         ovfStickyOut;

  ifu_mem_refill dut (
    .Clock                 (Clock),
    .Rst                   (Rst),
    .mem_reqTagIn          (reqTag),
    .mem_reqTagValidIn     (reqValid),
    .mem_rspTagOut         (mem_rspTagOut),
    .mem_rspInsLineOut     (mem_rspInsLineOut),
    .mem_rspInsLineValidOut(mem_rspInsLineValidOut),
    .imem_rdEnOut          (imem_rdEnOut),
    .imem_rdAddrOut        (imem_rdAddrOut),
    .imem_rdDataIn         (imem_rdDataIn),
    .busyOut               (busyOut),
    .ovfStickyOut          (ovfStickyOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  logic [31:0] memSalt = '0;
  bit          smpEn = 1'b0;
  logic [31:0] smpAddr = '0;

  // Reference model: request queue of depth 2 and a server that is `ph` cycles into a line.
  logic [27:0] tagQ[$];
  bit          act = 1'b0;
  int          ph = 0;
  logic [27:0] inTag = '0;
  bit          ovfM = 1'b0;
  bit          dup, pop, expEn, expRsp, expBusy;
  logic [31:0] expAddr;

  int          rspCycQ[$];
  logic [27:0] rspTagQ[$];
  logic [127:0] rspLineQ[$];
  int          rdCycQ[$];
  logic [31:0] rdAddrQ[$];
  int          rdEnCnt = 0;
  int          rspCnt = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ memSalt;
  endfunction

  function automatic logic [127:0] expLine(input logic [27:0] t);
    logic [127:0] l;
    l = '0;
    for (int b = 0; b < 4; b++) l[b*32 +: 32] = memWord({t, 2'(b), 2'b00});
    return l;
  endfunction

  task automatic chk(input string name, input logic [127:0] actual, input logic [127:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, required);
    end
  endtask

  // Memory: data for an address seen with rdEn in one cycle is presented during the next.
  initial begin
    imem_rdDataIn = '0;
    forever begin
      @(posedge Clock);
      #1;
      imem_rdDataIn = smpEn ? memWord(smpAddr) : $urandom;
    end
  end

  always @(negedge Clock) begin
    smpEn   = imem_rdEnOut;
    smpAddr = imem_rdAddrOut;
    if (!Rst) begin
      chk("rst_rdEn", imem_rdEnOut, 0);
      chk("rst_rdAddr", imem_rdAddrOut, 0);
      chk("rst_rspValid", mem_rspInsLineValidOut, 0);
      chk("rst_rspTag", mem_rspTagOut, 0);
      chk("rst_rspLine", mem_rspInsLineOut, 0);
      chk("rst_busy", busyOut, 0);
      chk("rst_ovf", ovfStickyOut, 0);
      tagQ.delete();
      act = 1'b0; ph = 0; inTag = '0; ovfM = 1'b0;
      rdEnCnt = 0; rspCnt = 0;
    end else begin
      expEn   = act && (ph >= 1) && (ph <= 4);
      expAddr = {inTag, 2'(ph - 1), 2'b00};
      expRsp  = act && (ph == 6);
      expBusy = act || (tagQ.size() != 0);
      chk("rdEn", imem_rdEnOut, expEn);
      if (expEn) chk("rdAddr", imem_rdAddrOut, expAddr);
      chk("rspValid", mem_rspInsLineValidOut, expRsp);
      if (expRsp) begin
        chk("rspTag", mem_rspTagOut, inTag);
        chk("rspLine", mem_rspInsLineOut, expLine(inTag));
      end
      chk("busy", busyOut, expBusy);
      chk("ovf", ovfStickyOut, ovfM);

      if (imem_rdEnOut) begin
        rdEnCnt++;
        rdCycQ.push_back(cyc);
        rdAddrQ.push_back(imem_rdAddrOut);
      end
      if (mem_rspInsLineValidOut) begin
        rspCnt++;
        rspCycQ.push_back(cyc);
        rspTagQ.push_back(mem_rspTagOut);
        rspLineQ.push_back(mem_rspInsLineOut);
      end

      dup = 1'b0;
`ifdef IFU_REFILL_DEDUP_EN
      if (reqValid) begin
        foreach (tagQ[i]) if (tagQ[i] == reqTag) dup = 1'b1;
        if (act && (inTag == reqTag)) dup = 1'b1;
      end
`endif
      pop = (tagQ.size() != 0) && (!act || (ph == 6));
      if (pop) begin
        inTag = tagQ.pop_front();
        act = 1'b1;
        ph = 1;
      end else if (act) begin
        if (ph == 6) act = 1'b0;
        else ph++;
      end
      if (reqValid && !dup) begin
        if (tagQ.size() < 2) tagQ.push_back(reqTag);
        else ovfM = 1'b1;
      end
    end
  end

  task automatic drive(input bit v, input logic [27:0] t);
    @(posedge Clock);
    #1;
    reqValid = v;
    reqTag   = t;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0);
  endtask

  task automatic doReset();
    @(posedge Clock);
    #1;
    Rst = 1'b0;
    reqValid = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Rst = 1'b1;
  endtask

  task automatic clearLog();
    rspCycQ.delete(); rspTagQ.delete(); rspLineQ.delete();
    rdCycQ.delete(); rdAddrQ.delete();
  endtask

  int start;
  int n5;

  initial begin
    Rst = 1'b0;
    reqValid = 1'b0;
    reqTag = '0;
    repeat (3) @(posedge Clock);
    #1;
    Rst = 1'b1;

    // Single refill, memory word = byte address.
    clearLog();
    drive(1'b1, 28'h0000100);
    start = cyc;
    idle(20);
    chk("single_nrsp", rspCycQ.size(), 1);
    if (rspCycQ.size() > 0) begin
      chk("single_cycle", rspCycQ[0], start + 7);
      chk("single_tag", rspTagQ[0], 28'h0000100);
      chk("single_line", rspLineQ[0], 128'h0000100C_00001008_00001004_00001000);
    end
    chk("single_nrd", rdAddrQ.size(), 4);
    for (int i = 0; i < rdAddrQ.size() && i < 4; i++) begin
      chk("single_rdCycle", rdCycQ[i], start + 2 + i);
      chk("single_rdAddr", rdAddrQ[i], 32'h1000 + 32'(4 * i));
    end

    // Back-to-back: all three accepted, pulses every 6 cycles.
    doReset();
    clearLog();
    drive(1'b1, 28'h1);
    start = cyc;
    drive(1'b1, 28'h2);
    drive(1'b1, 28'h3);
    idle(30);
    chk("b2b_nrsp", rspCycQ.size(), 3);
    for (int i = 0; i < rspCycQ.size() && i < 3; i++) begin
      chk("b2b_cycle", rspCycQ[i], start + 7 + 6 * i);
      chk("b2b_tag", rspTagQ[i], 28'(i + 1));
    end
    chk("b2b_ovf", ovfStickyOut, 0);

    // Overflow: five in a row, last two dropped, flag sticky.
    doReset();
    clearLog();
    for (int i = 0; i < 5; i++) drive(1'b1, 28'hA + 28'(i));
    idle(30);
    chk("ovf_nrsp", rspCycQ.size(), 3);
    for (int i = 0; i < rspTagQ.size() && i < 3; i++) chk("ovf_tag", rspTagQ[i], 28'hA + 28'(i));
    chk("ovf_flag", ovfStickyOut, 1);
    idle(10);
    chk("ovf_sticky", ovfStickyOut, 1);

    // Repeated tag 0x5 behind one filler request.
    doReset();
    clearLog();
    drive(1'b1, 28'h9);
    repeat (3) drive(1'b1, 28'h5);
    idle(30);
    n5 = 0;
    foreach (rspTagQ[i]) if (rspTagQ[i] == 28'h5) n5++;
`ifdef IFU_REFILL_DEDUP_EN
    chk("dup_n5", n5, 1);
    chk("dup_ovf", ovfStickyOut, 0);
`else
    chk("dup_n5", n5, 2);
    chk("dup_ovf", ovfStickyOut, 1);
`endif

    // Reset in the middle of a burst: no stale response afterwards.
    doReset();
    drive(1'b1, 28'h77);
    idle(3);
    doReset();
    clearLog();
    idle(20);
    chk("rstmid_nrsp", rspCycQ.size(), 0);
    chk("rstmid_nrd", rdAddrQ.size(), 0);
    chk("rstmid_busy", busyOut, 0);

    // Random traffic with a salted memory image and one reset in the middle.
    doReset();
    memSalt = $urandom;
    clearLog();
    for (int c = 0; c < 900; c++) begin
      if (c == 450) begin
        doReset();
      end else if ($urandom_range(0, 99) < 22) begin
        drive(1'b1, ($urandom_range(0, 1) == 1) ? 28'($urandom_range(0, 5)) : 28'($urandom));
      end else begin
        drive(1'b0, '0);
      end
    end
    idle(40);
    chk("rand_rdPerRsp", rdEnCnt, 4 * rspCnt);
    chk("rand_anyRsp", rspCnt > 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
